// File: rtl/zero_insert_pad_layer.sv
//------------------------------------------------------------------------------
// zero_insert_pad_layer
//   Streaming zero-padder with optional stride dilation (zero insertion between
//   input pixels), feeding transposed-convolution layers. Each frame is armed
//   by a start pulse; mode is captured at that moment:
//     mode 0 : border padding only
//     mode 1 : STRIDE-1 zero columns/rows between pixels, then border padding
//   Content samples pass through combinationally (zero latency); all other
//   output positions emit zeros without consuming input.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   start, mode      frame start request and mode (sampled on start in IDLE)
//   valid_in/ready_in/data_in     input stream (signed samples)
//   valid_out/ready_out/data_out  output stream (signed samples)
//   last_out         marks the final sample of the frame
//   busy             frame in progress
//   frame_done       one-cycle pulse after the final sample fires
//
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module zero_insert_pad_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 1,
  parameter int IMG_WIDTH  = 14,
  parameter int IMG_HEIGHT = 14,
  parameter int STRIDE     = 2,
  parameter int PAD_TOP    = 1,
  parameter int PAD_BOTTOM = 2,
  parameter int PAD_LEFT   = 1,
  parameter int PAD_RIGHT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         ready_in,
  input  logic                         ready_out,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         last_out,
  output logic                         busy,
  output logic                         frame_done
);

  // Output geometry for stride 1 (mode 0) and STRIDE (mode 1)
  localparam int OW1 = PAD_LEFT + IMG_WIDTH + PAD_RIGHT;
  localparam int OH1 = PAD_TOP + IMG_HEIGHT + PAD_BOTTOM;
  localparam int OWS = PAD_LEFT + (IMG_WIDTH - 1) * STRIDE + 1 + PAD_RIGHT;
  localparam int OHS = PAD_TOP + (IMG_HEIGHT - 1) * STRIDE + 1 + PAD_BOTTOM;

  localparam int MAXW = (OW1 > OWS) ? OW1 : OWS;
  localparam int MAXH = (OH1 > OHS) ? OH1 : OHS;
  localparam int MAXD = (MAXW > MAXH) ? MAXW : MAXH;
  localparam int CW   = $clog2(MAXD + 1);
  localparam int PW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CW-1:0]  OW1_M1 = CW'(OW1 - 1);
  localparam logic [CW-1:0]  OWS_M1 = CW'(OWS - 1);
  localparam logic [CW-1:0]  OH1_M1 = CW'(OH1 - 1);
  localparam logic [CW-1:0]  OHS_M1 = CW'(OHS - 1);
  localparam logic [CW-1:0]  X_LO   = CW'(PAD_LEFT);
  localparam logic [CW-1:0]  Y_LO   = CW'(PAD_TOP);
  localparam logic [CW-1:0]  X_HI1  = CW'(PAD_LEFT + IMG_WIDTH - 1);
  localparam logic [CW-1:0]  X_HIS  = CW'(PAD_LEFT + (IMG_WIDTH - 1) * STRIDE);
  localparam logic [CW-1:0]  Y_HI1  = CW'(PAD_TOP + IMG_HEIGHT - 1);
  localparam logic [CW-1:0]  Y_HIS  = CW'(PAD_TOP + (IMG_HEIGHT - 1) * STRIDE);
  localparam logic [PW-1:0]  S_M1   = PW'(STRIDE - 1);
  localparam logic [CHW-1:0] CH_M1  = CHW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             mode_r;
  logic [CHW-1:0]   ch;
  logic [CW-1:0]    out_x;
  logic [CW-1:0]    out_y;
  logic [PW-1:0]    phase_x;
  logic [PW-1:0]    phase_y;

  logic [CW-1:0]    ow_m1, oh_m1, x_hi, y_hi;
  logic [PW-1:0]    s_m1;
  logic             x_content, y_content, content;
  logic             run, fire, last_pos;

  // Geometry selected by the mode captured at frame start
  always_comb begin
    ow_m1 = mode_r ? OWS_M1 : OW1_M1;
    oh_m1 = mode_r ? OHS_M1 : OH1_M1;
    x_hi  = mode_r ? X_HIS  : X_HI1;
    y_hi  = mode_r ? Y_HIS  : Y_HI1;
    s_m1  = mode_r ? S_M1   : '0;
  end

  // A position carries input data only inside the image span and on a
  // stride phase of zero; phases stay 0 through the leading pad.
  assign x_content = (out_x >= X_LO) && (out_x <= x_hi) && (phase_x == '0);
  assign y_content = (out_y >= Y_LO) && (out_y <= y_hi) && (phase_y == '0);
  assign content   = x_content && y_content;

  assign run      = (state == RUN);
  assign fire     = valid_out && ready_out;
  assign last_pos = (ch == CH_M1) && (out_x == ow_m1) && (out_y == oh_m1);

  assign busy       = run;
  assign frame_done = (state == DONE);
  assign last_out   = run && last_pos;

  always_comb begin
    valid_out = 1'b0;
    ready_in  = 1'b0;
    data_out  = '0;
    if (run) begin
      if (content) begin
        valid_out = valid_in;
        ready_in  = ready_out;
        data_out  = data_in;
      end else begin
        valid_out = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mode_r  <= 1'b0;
      ch      <= '0;
      out_x   <= '0;
      out_y   <= '0;
      phase_x <= '0;
      phase_y <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            mode_r  <= mode;
            ch      <= '0;
            out_x   <= '0;
            out_y   <= '0;
            phase_x <= '0;
            phase_y <= '0;
          end
        end
        RUN: begin
          if (fire) begin
            if (ch == CH_M1) begin
              ch <= '0;
              if (out_x == ow_m1) begin
                out_x   <= '0;
                phase_x <= '0;
                if (out_y == oh_m1) begin
                  out_y   <= '0;
                  phase_y <= '0;
                end else begin
                  out_y <= out_y + 1'b1;
                  if (out_y >= Y_LO)
                    phase_y <= (phase_y == s_m1) ? '0 : phase_y + 1'b1;
                  else
                    phase_y <= '0;
                end
              end else begin
                out_x <= out_x + 1'b1;
                if (out_x >= X_LO)
                  phase_x <= (phase_x == s_m1) ? '0 : phase_x + 1'b1;
                else
                  phase_x <= '0;
              end
            end else begin
              ch <= ch + 1'b1;
            end
            if (last_pos)
              state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zero_insert_pad_layer.sv
`default_nettype none

module tb_zero_insert_pad_layer;

  localparam int DW = 16;
  localparam int W  = 2;
  localparam int H  = 2;
  localparam int S  = 2;
  localparam int PT = 1;
  localparam int PB = 2;
  localparam int PL = 1;
  localparam int PR = 2;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst, start, mode, valid_in, ready_out, sel;
  logic signed [DW-1:0] data_in;

  logic start_a, start_b;
  logic ready_in_a, valid_out_a, last_out_a, busy_a, frame_done_a;
  logic ready_in_b, valid_out_b, last_out_b, busy_b, frame_done_b;
  logic signed [DW-1:0] data_out_a, data_out_b;

  logic ready_in, valid_out, last_out, busy, frame_done;
  logic signed [DW-1:0] data_out;

  int npass = 0;
  int ntotal = 0;

  int inq[$];
  int exp_d[$];
  bit exp_c[$];

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign ready_in   = sel ? ready_in_b   : ready_in_a;
  assign valid_out  = sel ? valid_out_b  : valid_out_a;
  assign last_out   = sel ? last_out_b   : last_out_a;
  assign busy       = sel ? busy_b       : busy_a;
  assign frame_done = sel ? frame_done_b : frame_done_a;
  assign data_out   = sel ? data_out_b   : data_out_a;

  zero_insert_pad_layer #(
    .DATA_WIDTH(DW), .CHANNELS(1), .IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(S),
    .PAD_TOP(PT), .PAD_BOTTOM(PB), .PAD_LEFT(PL), .PAD_RIGHT(PR)
  ) u_dut_c1 (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode),
    .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in_a),
    .ready_out(ready_out), .valid_out(valid_out_a), .data_out(data_out_a),
    .last_out(last_out_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  zero_insert_pad_layer #(
    .DATA_WIDTH(DW), .CHANNELS(2), .IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(S),
    .PAD_TOP(PT), .PAD_BOTTOM(PB), .PAD_LEFT(PL), .PAD_RIGHT(PR)
  ) u_dut_c2 (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode),
    .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in_b),
    .ready_out(ready_out), .valid_out(valid_out_b), .data_out(data_out_b),
    .last_out(last_out_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    ntotal++;
    assert (obs === expv) begin
      npass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: enumerate output raster; a pixel is content when it lies in the
  // image span and its offset from the pad edge is a multiple of the stride.
  task automatic build(input int chn, input bit m);
    int s, ow, oh;
    bit cx, cy;
    s  = m ? S : 1;
    ow = PL + (W - 1) * s + 1 + PR;
    oh = PT + (H - 1) * s + 1 + PB;
    exp_d.delete();
    exp_c.delete();
    for (int y = 0; y < oh; y++)
      for (int x = 0; x < ow; x++)
        for (int c = 0; c < chn; c++) begin
          cx = (x >= PL) && (x <= PL + (W - 1) * s) && ((x - PL) % s == 0);
          cy = (y >= PT) && (y <= PT + (H - 1) * s) && ((y - PT) % s == 0);
          if (cx && cy) begin
            exp_d.push_back(inq[(((y - PT) / s) * W + (x - PL) / s) * chn + c]);
            exp_c.push_back(1'b1);
          end else begin
            exp_d.push_back(0);
            exp_c.push_back(1'b0);
          end
        end
  endtask

  task automatic run_frame(input bit chsel, input bit m, input int stall,
                           input int mid_start_at, input int rst_at,
                           input bit seq_data);
    int chn, n, idx, in_idx, cyc;
    bit fire, acc;
    chn = chsel ? 2 : 1;
    inq.delete();
    for (int i = 0; i < W * H * chn; i++)
      inq.push_back(seq_data ? i + 1 : int'($urandom_range(65535)) - 32768);
    build(chn, m);
    n = exp_d.size();
    idx = 0;
    in_idx = 0;
    cyc = 0;

    @(posedge clk); #1;
    sel = chsel;
    start = 1'b1;
    mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m;
    chk("busy_after_start", busy, 1);

    while (idx < n && cyc < BUDGET) begin
      valid_in  = ($urandom_range(99) >= stall);
      ready_out = ($urandom_range(99) >= stall);
      data_in   = (in_idx < inq.size()) ? DW'(inq[in_idx]) : DW'($urandom);
      start     = (idx == mid_start_at);
      mode      = ~m;
      @(negedge clk);
      chk("valid_out", valid_out, exp_c[idx] ? valid_in : 1'b1);
      chk("ready_in", ready_in, exp_c[idx] && ready_out);
      chk("busy", busy, 1);
      if (valid_out) begin
        chk($sformatf("data_out[%0d]", idx), data_out, exp_d[idx]);
        chk("last_out", last_out, idx == n - 1);
      end
      fire = valid_out && ready_out;
      acc  = valid_in && ready_in;
      if (idx == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_in", ready_in, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        #2;
        rst = 1'b0;
        start = 1'b0;
        valid_in = 1'b0;
        ready_out = 1'b0;
        return;
      end
      @(posedge clk);
      if (fire) idx++;
      if (acc) in_idx++;
      #1;
      cyc++;
    end
    start = 1'b0;
    valid_in = 1'b0;
    ready_out = 1'b1;
    chk("no_timeout", cyc < BUDGET, 1);
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_in_done", busy, 0);
    chk("valid_out_in_done", valid_out, 0);
    chk("inputs_consumed", in_idx, W * H * chn);
    @(posedge clk); #1;
    chk("frame_done_cleared", frame_done, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    valid_in = 1'b0;
    ready_out = 1'b1;
    sel = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      chk("reset_valid_out", valid_out, 0);
      chk("reset_ready_in", ready_in, 0);
      chk("reset_busy", busy, 0);
      chk("reset_data_out", data_out, 0);
    end
    sel = 1'b0;
    rst = 1'b0;

    run_frame(1'b0, 1'b0, 0, -1, -1, 1'b1);   // 5x5 pad only, data 1..4
    run_frame(1'b0, 1'b1, 0, -1, -1, 1'b1);   // 6x6 dilated
    run_frame(1'b1, 1'b0, 0, -1, -1, 1'b1);   // two channels, 50 samples
    run_frame(1'b0, 1'b1, 30, -1, -1, 1'b0);  // random stalls
    run_frame(1'b0, 1'b1, 0, 5, -1, 1'b0);    // mid-frame start ignored
    run_frame(1'b0, 1'b0, 0, 7, -1, 1'b0);    // back-to-back, other mode
    run_frame(1'b1, 1'b1, 30, 8, -1, 1'b0);   // two channels dilated, stalls
    run_frame(1'b0, 1'b1, 0, -1, 10, 1'b0);   // reset at output sample 10
    run_frame(1'b0, 1'b1, 20, -1, -1, 1'b0);  // full frame after reset

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zero_insert_pad_layer.md
Name: zero_insert_pad_layer

Overview:
Multi-channel streaming zero-padder with optional zero insertion between pixels (stride dilation). It feeds the transposed-convolution layers of the FI-GAN generator.
- Mode 0: border padding only.
- Mode 1: inserts STRIDE-1 zero columns/rows between input pixels, then pads the border.
- Frames are re-armed by a start pulse. The block does not latch permanently after one frame, and there is no fixed flush counter.

Parameters:
- DATA_WIDTH, 16, sample width (signed).
- CHANNELS, 1, samples per pixel, interleaved channel-innermost on both streams.
- IMG_WIDTH, 14, input pixels per row.
- IMG_HEIGHT, 14, input rows.
- STRIDE, 2, dilation factor used in mode 1 (>=1).
- PAD_TOP, 1, zero rows above.
- PAD_BOTTOM, 2, zero rows below.
- PAD_LEFT, 1, zero columns left.
- PAD_RIGHT, 2, zero columns right.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle frame start request
- mode  in  1  0 = pad only, 1 = insert + pad; sampled only when start is accepted
- valid_in  in  1  input sample valid
- data_in  in  DATA_WIDTH  signed input sample
- ready_in  out  1  input sample accepted when valid_in && ready_in
- ready_out  in  1  downstream ready
- valid_out  out  1  output sample valid
- data_out  out  DATA_WIDTH  signed output sample
- last_out  out  1  high with the final sample of the frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the final sample fires

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (any time, including mid-frame):
  - state = IDLE; all counters 0; mode_r = 0.
  - valid_out = 0, ready_in = 0, last_out = 0, busy = 0, frame_done = 0, data_out = 0.
  - No partial-frame resume after reset.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when start = 1.
  - Latch mode into mode_r; set S = STRIDE if mode_r else 1.
  - Clear out_x, out_y, ch.
  - start is ignored in RUN and DONE.
- RUN -> DONE on the cycle the last sample fires (fire = valid_out && ready_out).
- DONE -> IDLE unconditionally on the next cycle. frame_done = 1 only while in DONE.
- Output geometry:
  - OW = PAD_LEFT + (IMG_WIDTH-1)*S + 1 + PAD_RIGHT.
  - OH = PAD_TOP + (IMG_HEIGHT-1)*S + 1 + PAD_BOTTOM.
  - Order is row-major, CHANNELS samples per output pixel (ch innermost).
- Content position: out_x in [PAD_LEFT, PAD_LEFT+(IMG_WIDTH-1)*S], phase_x == 0, and the same holds for y.
  - phase_x/phase_y are counters modulo S, reset at the pad edge. No divider or modulo operator is used.
- In RUN at a content position (combinational pass-through, zero latency):
  - valid_out = valid_in, data_out = data_in, ready_in = ready_out.
- In RUN elsewhere (zero positions):
  - valid_out = 1, data_out = 0, ready_in = 0.
- Outside RUN: valid_out = 0, ready_in = 0, data_out = 0.
- Counters advance only on fire, in this order: ch -> out_x/phase_x -> out_y/phase_y.
  - Each wraps to 0 at its limit: CHANNELS-1, OW-1, OH-1 respectively.
- last_out = busy && (ch == CHANNELS-1) && (out_x == OW-1) && (out_y == OH-1). It qualifies the current sample.
- busy = (state == RUN).
- Backpressure: with ready_out = 0, counters, data_out and valid_out all hold. This holds for both content and zero samples.
- Input consumption per frame is exactly IMG_WIDTH*IMG_HEIGHT*CHANNELS samples. Extra input is not accepted until the next start.
- Counter widths: $clog2 of max(OW, OH) + 1 for stride 1 and STRIDE. Geometry arithmetic is unsigned, with no truncation for the defaults.
- Simultaneous start and final fire: start is ignored, because the state is RUN.

Test Plan:
- IMG 2x2, CHANNELS = 1, pads T1/B2/L1/R2, mode 0, data 1..4, ready_out = 1 → 25 samples.
  - Data at indices 6, 7, 11, 12; all others 0.
  - last_out on sample 24; frame_done on the next cycle.
- Same setup, mode 1, STRIDE = 2 → 6x6 = 36 samples.
  - Data at (x, y) = (1,1), (3,1), (1,3), (3,3) = 1, 2, 3, 4; zeros elsewhere.
  - ready_in high only at those four positions.
- CHANNELS = 2, mode 0, same pads, pairs (a0,a1)…(d0,d1) → 50 samples.
  - Channel pairs stay adjacent at pixel indices 6, 7, 11, 12.
- Random ready_out / valid_in stalls (30% low), mode 1 → output sequence identical to the unstalled run.
  - No sample is dropped or duplicated; data_out is held during stalls.
- start pulsed mid-frame → ignored. Two back-to-back frames with different modes → each frame's geometry matches the mode latched at its own start.
- rst asserted at output sample 10 → all outputs 0 immediately (asynchronously). After release and a new start, a full correct frame is produced.
